// File: rtl/braid_mix_sequencer_if.sv
// Actuation bus between the braid mix sequencer (master) and the valve driver (slave).
// Handshake: a step transfers on any clock edge where act_valid & act_ready are both high;
// the master holds act_valid and the payload stable until that edge, and the slave may
// drive act_ready at any time without looking at act_valid.
interface braid_mix_sequencer_if #(
  parameter int SW = 2,
  parameter int CW = 4,
  parameter int HW = 2
);
  logic          act_valid;
  logic          act_ready;
  logic [SW-1:0] act_stage;
  logic [CW-1:0] act_col;
  logic [HW-1:0] act_src_a;
  logic [HW-1:0] act_src_b;

  modport master (
    output act_valid, act_stage, act_col, act_src_a, act_src_b,
    input  act_ready
  );

  modport slave (
    input  act_valid, act_stage, act_col, act_src_a, act_src_b,
    output act_ready
  );
endinterface

// File: rtl/braid_mix_sequencer.sv
// Run-time sequencer for a braided mixer array: one handshaked actuation per mixer, then
// timed mix and flush phases. Optional step counter enabled by defining BRAID_STEP_COUNT_EN.
module braid_mix_sequencer #(
  parameter int CHANNELS     = 3,
  parameter int STAGES       = 3,
  parameter int COLUMNS      = 16,
  parameter int MIX_CYCLES   = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  braid_mix_sequencer_if.master act,
  output logic       mix_en,
  output logic       flush_en,
  output logic [2:0] dbg_state
`ifdef BRAID_STEP_COUNT_EN
  ,
  output logic [15:0] step_count
`endif
);
  localparam int SW   = (STAGES   > 2) ? $clog2(STAGES)   : 1;
  localparam int CW   = (COLUMNS  > 2) ? $clog2(COLUMNS)  : 1;
  localparam int HW   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int TMAX = (MIX_CYCLES > FLUSH_CYCLES) ? MIX_CYCLES : FLUSH_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_MIX   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic          mix_last;
  logic          flush_last;
  logic          step_end;
  logic          last_col;
  logic          last_step;
  logic [HW-1:0] src_a_inc;
  logic [HW-1:0] src_b_inc;

  assign dbg_state = state;

  always_comb begin
    mix_last   = (state == S_MIX) && (tmr == TW'(MIX_CYCLES - 1));
    flush_last = (state == S_FLUSH) && (tmr == TW'(FLUSH_CYCLES - 1));
    step_end   = (mix_last && (FLUSH_CYCLES == 0)) || flush_last;
    last_col   = (act.act_col == CW'(COLUMNS - 1));
    last_step  = last_col && (act.act_stage == '0);
    // Braid partners walk modulo CHANNELS alongside the column, avoiding a divider.
    src_a_inc  = (act.act_src_a == HW'(CHANNELS - 1)) ? '0 : act.act_src_a + 1'b1;
    src_b_inc  = (act.act_src_b == HW'(CHANNELS - 1)) ? '0 : act.act_src_b + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tmr           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      mix_en        <= 1'b0;
      flush_en      <= 1'b0;
      act.act_valid <= 1'b0;
      act.act_stage <= '0;
      act.act_col   <= '0;
      act.act_src_a <= '0;
      act.act_src_b <= '0;
`ifdef BRAID_STEP_COUNT_EN
      step_count    <= '0;
`endif
    end else if (abort) begin
      // Abort beats everything, including a transfer on this very edge.
      state         <= S_IDLE;
      tmr           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b1;
      mix_en        <= 1'b0;
      flush_en      <= 1'b0;
      act.act_valid <= 1'b0;
      act.act_stage <= '0;
      act.act_col   <= '0;
      act.act_src_a <= '0;
      act.act_src_b <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_ISSUE;
            busy          <= 1'b1;
            aborted       <= 1'b0;
            act.act_valid <= 1'b1;
            act.act_stage <= SW'(STAGES - 1);
            act.act_col   <= '0;
            act.act_src_a <= '0;
            act.act_src_b <= HW'(1);
`ifdef BRAID_STEP_COUNT_EN
            step_count    <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (act.act_ready) begin
            state         <= S_MIX;
            act.act_valid <= 1'b0;
            mix_en        <= 1'b1;
            tmr           <= '0;
          end
        end
        S_MIX: begin
          if (mix_last) begin
            mix_en <= 1'b0;
            tmr    <= '0;
`ifdef BRAID_STEP_COUNT_EN
            if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
`endif
            if (FLUSH_CYCLES != 0) begin
              state    <= S_FLUSH;
              flush_en <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_last) begin
            flush_en <= 1'b0;
            tmr      <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          act.act_stage <= '0;
          act.act_col   <= '0;
          act.act_src_a <= '0;
          act.act_src_b <= '0;
        end
        default: state <= S_IDLE;
      endcase

      // Column advances first; a column wrap steps down one rank.
      if (step_end) begin
        if (last_step) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          state         <= S_ISSUE;
          act.act_valid <= 1'b1;
          if (last_col) begin
            act.act_col   <= '0;
            act.act_stage <= act.act_stage - 1'b1;
            act.act_src_a <= '0;
            act.act_src_b <= HW'(1);
          end else begin
            act.act_col   <= act.act_col + 1'b1;
            act.act_src_a <= src_a_inc;
            act.act_src_b <= src_b_inc;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_braid_mix_sequencer.sv
// Directed-plus-random bench for braid_mix_sequencer: a default-sized instance and a
// minimal one (1x1 array, no flush), checked against a step-list model of the schedule.
module tb_braid_mix_sequencer;
  localparam int STAGES = 3, COLUMNS = 16, CHANNELS = 3, MIX_C = 8, FLUSH_C = 2;
  localparam int STEP_LAT = 1 + MIX_C + FLUSH_C;
  localparam int RUN_LEN  = STAGES * COLUMNS * STEP_LAT + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, start1, abort1;
  logic busy0, done0, aborted0, mix_en0, flush_en0;
  logic busy1, done1, aborted1, mix_en1, flush_en1;
  logic [2:0] dbg_state0, dbg_state1;
`ifdef BRAID_STEP_COUNT_EN
  logic [15:0] step_count0, step_count1;
`endif

  int tests = 0;
  int failures = 0;
  int overlap = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got0_q[$];
  logic [31:0] got1_q[$];

  braid_mix_sequencer_if #(.SW(2), .CW(4), .HW(2)) act0 ();
  braid_mix_sequencer_if #(.SW(1), .CW(1), .HW(2)) act1 ();

  braid_mix_sequencer #(
    .CHANNELS(CHANNELS), .STAGES(STAGES), .COLUMNS(COLUMNS),
    .MIX_CYCLES(MIX_C), .FLUSH_CYCLES(FLUSH_C)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy0), .done(done0), .aborted(aborted0), .act(act0),
    .mix_en(mix_en0), .flush_en(flush_en0), .dbg_state(dbg_state0)
`ifdef BRAID_STEP_COUNT_EN
    , .step_count(step_count0)
`endif
  );

  braid_mix_sequencer #(
    .CHANNELS(3), .STAGES(1), .COLUMNS(1), .MIX_CYCLES(1), .FLUSH_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .aborted(aborted1), .act(act1),
    .mix_en(mix_en1), .flush_en(flush_en1), .dbg_state(dbg_state1)
`ifdef BRAID_STEP_COUNT_EN
    , .step_count(step_count1)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input int s, input int c, input int a, input int b);
    return {8'(s), 8'(c), 8'(a), 8'(b)};
  endfunction

  // Transfer monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (act0.act_valid && act0.act_ready && !abort)
      got0_q.push_back(pack(act0.act_stage, act0.act_col, act0.act_src_a, act0.act_src_b));
    if (act1.act_valid && act1.act_ready && !abort1)
      got1_q.push_back(pack(act1.act_stage, act1.act_col, act1.act_src_a, act1.act_src_b));
    if ((mix_en0 && flush_en0) || (mix_en1 && flush_en1)) overlap++;
  end

  // Reference schedule: ranks top-down, columns left-to-right, partners modulo CHANNELS.
  task automatic build_model(input int stages, input int columns, input int channels);
    exp_q.delete();
    for (int s = stages - 1; s >= 0; s--)
      for (int c = 0; c < columns; c++)
        exp_q.push_back(pack(s, c, c % channels, (c + 1) % channels));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_payloads(input string tag, input int base, input int n_exp);
    check({tag, "_count"}, got0_q.size() - base, n_exp);
    for (int i = 0; i < n_exp && base + i < got0_q.size(); i++)
      check({tag, "_payload"}, got0_q[base + i], exp_q[i]);
  endtask

  // Drivers
  task automatic tick(inout int cyc);
    @(posedge clk); #1; cyc++;
  endtask

  task automatic launch(inout int cyc);
    cyc = 0; start = 1'b1;
    tick(cyc);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, input bit poke_start, inout int cyc,
                           output bit got);
    got = 1'b0;
    while (!got && cyc < 5000) begin
      if (done0) got = 1'b1;
      else begin
        if (rand_ready) act0.act_ready = ($urandom_range(0, 3) != 0);
        if (poke_start) start = ($urandom_range(0, 15) == 0);
        tick(cyc);
      end
    end
    start = 1'b0;
  endtask

  logic [31:0] cur_payload;
  logic [2:0]  idle_code;
  int          cyc;
  int          base;
  bit          got;
  bit          seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; act0.act_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; act1.act_ready = 1'b1;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_aborted", aborted0, 0);
    check("rst_valid", act0.act_valid, 0);
    check("rst_mix", mix_en0, 0);
    check("rst_flush", flush_en0, 0);
    check("rst_payload", pack(act0.act_stage, act0.act_col, act0.act_src_a, act0.act_src_b), 0);
`ifdef BRAID_STEP_COUNT_EN
    check("rst_step_count", step_count0, 0);
`endif
    idle_code = dbg_state0;
    rst_n = 1'b1;
    tick(cyc);

    // Full run with a driver that is always ready
    build_model(STAGES, COLUMNS, CHANNELS);
    act0.act_ready = 1'b1;
    base = got0_q.size();
    launch(cyc);
    wait_done(0, 0, cyc, got);
    check("run1_done_seen", got, 1);
    check("run1_length", cyc, RUN_LEN);
    check("run1_busy_in_done", busy0, 1);
    tick(cyc);
    check("run1_done_pulse", done0, 0);
    check("run1_busy_after", busy0, 0);
    check("run1_idle_state", dbg_state0, idle_code);
    check_payloads("run1", base, STAGES * COLUMNS);
    check("run1_first", got0_q[base], pack(2, 0, 0, 1));
    check("run1_second", got0_q[base + 1], pack(2, 1, 1, 2));
    check("run1_third", got0_q[base + 2], pack(2, 2, 2, 0));
    check("run1_last", got0_q[got0_q.size() - 1], pack(0, 15, 0, 1));
`ifdef BRAID_STEP_COUNT_EN
    check("run1_step_count", step_count0, STAGES * COLUMNS);
`endif

    // Ready held low through the first ISSUE, then random backpressure
    act0.act_ready = 1'b0;
    base = got0_q.size();
    launch(cyc);
    for (int i = 1; i <= 5; i++) begin
      cur_payload = pack(act0.act_stage, act0.act_col, act0.act_src_a, act0.act_src_b);
      check("stall_valid", act0.act_valid, 1);
      check("stall_payload", cur_payload, exp_q[0]);
      check("stall_no_mix", mix_en0, 0);
      if (i < 5) tick(cyc);
    end
    act0.act_ready = 1'b1;
    tick(cyc);
    check("stall_mix_starts", mix_en0, 1);
    check("stall_valid_drops", act0.act_valid, 0);
    wait_done(1, 0, cyc, got);
    check("stall_done_seen", got, 1);
    act0.act_ready = 1'b1;
    tick(cyc);
    check_payloads("stall", base, STAGES * COLUMNS);

    // Abort during MIX of the seventh step
    base = got0_q.size();
    launch(cyc);
    while (cyc < 6 * STEP_LAT + 4) tick(cyc);
    check("abort_in_mix", mix_en0, 1);
    abort = 1'b1;
    tick(cyc);
    abort = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_valid", act0.act_valid, 0);
    check("abort_mix", mix_en0, 0);
    check("abort_flush", flush_en0, 0);
    check("abort_done", done0, 0);
    check("abort_sticky", aborted0, 1);
    seen = 1'b0;
    repeat (20) begin
      tick(cyc);
      if (done0 || busy0) seen = 1'b1;
    end
    check("abort_quiet", seen, 0);
    check("abort_still_set", aborted0, 1);
    check_payloads("abort", base, 7);

    base = got0_q.size();
    launch(cyc);
    check("restart_aborted_clr", aborted0, 0);
    check("restart_payload", pack(act0.act_stage, act0.act_col, act0.act_src_a, act0.act_src_b),
          pack(2, 0, 0, 1));
    wait_done(0, 0, cyc, got);
    check("restart_length", cyc, RUN_LEN);
    tick(cyc);
    check_payloads("restart", base, STAGES * COLUMNS);

    // Start pokes while busy change nothing
    base = got0_q.size();
    launch(cyc);
    wait_done(0, 1, cyc, got);
    check("poke_length", cyc, RUN_LEN);
    tick(cyc);
    check_payloads("poke", base, STAGES * COLUMNS);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick(cyc);
    start = 1'b0; abort = 1'b0;
    check("startabort_aborted", aborted0, 1);
    check("startabort_busy", busy0, 0);
    check("startabort_valid", act0.act_valid, 0);
    seen = 1'b0;
    repeat (5) begin
      tick(cyc);
      if (busy0 || act0.act_valid) seen = 1'b1;
    end
    check("startabort_no_run", seen, 0);

    // Abort on the same edge as a transfer
    act0.act_ready = 1'b0;
    launch(cyc);
    tick(cyc);
    act0.act_ready = 1'b1; abort = 1'b1;
    tick(cyc);
    abort = 1'b0;
    check("xfer_abort_mix", mix_en0, 0);
    check("xfer_abort_valid", act0.act_valid, 0);
    check("xfer_abort_sticky", aborted0, 1);
`ifdef BRAID_STEP_COUNT_EN
    check("xfer_abort_count", step_count0, 0);
`endif

    // Asynchronous reset mid-run
    launch(cyc);
    repeat (15) tick(cyc);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", busy0, 0);
    check("arst_mix", mix_en0 | flush_en0, 0);
    check("arst_valid", act0.act_valid, 0);
    check("arst_payload", pack(act0.act_stage, act0.act_col, act0.act_src_a, act0.act_src_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(cyc);

    // Minimal array: one mixer, one mix cycle, no flush
    cyc = 0; start1 = 1'b1;
    tick(cyc);
    start1 = 1'b0;
    while (!done1 && cyc < 100) tick(cyc);
    check("min_done_seen", done1, 1);
    check("min_length", cyc, 1 * 1 * (1 + 1 + 0) + 1);
    check("min_xfers", got1_q.size(), 1);
    if (got1_q.size() > 0) check("min_payload", got1_q[0], pack(0, 0, 0, 1));
`ifdef BRAID_STEP_COUNT_EN
    check("min_step_count", step_count1, 1);
`endif
    tick(cyc);
    check("min_idle", busy1, 0);

    check("mix_flush_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
